// File: rtl/systolic_sched_pkg.sv
// Shared types for the systolic scheduler: FSM state encoding and legal kernel sizes.
package sys_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        NEXT   = 3'd4
    } state_e;

    localparam logic [4:0] WDIM_2X2 = 5'd4;
    localparam logic [4:0] WDIM_3X3 = 5'd9;
    localparam logic [4:0] WDIM_4X4 = 5'd16;
    localparam logic [4:0] WDIM_5X5 = 5'd25;

    function automatic logic wdim_legal(input logic [4:0] dim);
        return (dim == WDIM_2X2) || (dim == WDIM_3X3) || (dim == WDIM_4X4) || (dim == WDIM_5X5);
    endfunction

endpackage

// File: rtl/systolic_sched_if.sv
// Job control, buffer handshakes and array controls between a job master and the systolic scheduler.
interface systolic_sched_if #(
    parameter int COL   = 32,
    parameter int ACT_W = 10
);
    logic             start;
    logic             abort;
    logic [4:0]       cfg_weight_dim;
    logic [7:0]       cfg_num_tiles;
    logic [ACT_W-1:0] cfg_act_len;
    logic             wgt_valid;
    logic             act_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [7:0]       tile_idx;
    logic [COL-1:0]   w_ps;
    logic [COL-1:0]   out_en;
    logic             wgt_rd;
    logic             act_rd;

    modport master (
        output start, abort, cfg_weight_dim, cfg_num_tiles, cfg_act_len,
        output wgt_valid, act_valid, out_ready,
        input  busy, done, cfg_err, tile_idx, w_ps, out_en, wgt_rd, act_rd
    );

    modport slave (
        input  start, abort, cfg_weight_dim, cfg_num_tiles, cfg_act_len,
        input  wgt_valid, act_valid, out_ready,
        output busy, done, cfg_err, tile_idx, w_ps, out_en, wgt_rd, act_rd
    );
endinterface

// File: rtl/systolic_sched_beat_cnt.sv
// Loadable beat down-counter; load wins over enable and the count holds at zero.
// Latency: one cycle from load/enable to count; no backpressure of its own.
module sched_beat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/systolic_sched.sv
// Systolic array tile scheduler: weight load, activation stream and column drain per tile.
// Latency: first LOAD_W cycle follows start; done is a registered pulse one cycle after the last NEXT.
// Backpressure: each phase advances only on wgt_valid / act_valid / out_ready; stall_cnt exists with SYSTOLIC_SCHED_PERF_EN.
module systolic_sched
    import sys_pkg::*;
#(
    parameter int COL   = 32,
    parameter int ACT_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    systolic_sched_if.slave bus
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);
    localparam int             DW      = $clog2(COL + 1);
    localparam logic [COL-1:0] COL_ONE = COL'(1);

    state_e           state_q, state_d;
    logic [4:0]       wdim_q, wdim_d;
    logic [7:0]       ntiles_q, ntiles_d;
    logic [ACT_W-1:0] alen_q, alen_d;
    logic [7:0]       tile_q, tile_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             w_beat, a_beat, d_beat;
    logic             w_zero, a_zero, d_zero;
    logic [4:0]       wcnt_unused;
    logic [ACT_W-1:0] acnt_unused;
    logic [DW-1:0]    dcnt;

    assign w_beat = (state_q == LOAD_W) && bus.wgt_valid;
    assign a_beat = (state_q == STREAM) && bus.act_valid;
    assign d_beat = (state_q == DRAIN)  && bus.out_ready;

    // Counters preload beats-minus-one whenever their phase is inactive, so zero marks the final beat.
    sched_beat_cnt #(.W(5)) u_wcnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q != LOAD_W),
        .en_i   (w_beat),
        .val_i  (wdim_d - 5'd1),
        .cnt_o  (wcnt_unused),
        .zero_o (w_zero)
    );

    sched_beat_cnt #(.W(ACT_W)) u_acnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q != STREAM),
        .en_i   (a_beat),
        .val_i  (alen_d - 1'b1),
        .cnt_o  (acnt_unused),
        .zero_o (a_zero)
    );

    sched_beat_cnt #(.W(DW)) u_dcnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q != DRAIN),
        .en_i   (d_beat),
        .val_i  (DW'(COL - 1)),
        .cnt_o  (dcnt),
        .zero_o (d_zero)
    );

    always_comb begin
        state_d  = state_q;
        wdim_d   = wdim_q;
        ntiles_d = ntiles_q;
        alen_d   = alen_q;
        tile_d   = tile_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            tile_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (!wdim_legal(bus.cfg_weight_dim)) begin
                            err_d = 1'b1;
                        end else begin
                            wdim_d   = bus.cfg_weight_dim;
                            ntiles_d = bus.cfg_num_tiles;
                            alen_d   = bus.cfg_act_len;
                            tile_d   = '0;
                            if (bus.cfg_num_tiles == '0)
                                done_d = 1'b1;
                            else
                                state_d = LOAD_W;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_beat && w_zero)
                        state_d = (alen_q == '0) ? DRAIN : STREAM;
                end
                STREAM: begin
                    if (a_beat && a_zero)
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (d_beat && d_zero)
                        state_d = NEXT;
                end
                NEXT: begin
                    tile_d = tile_q + 8'd1;
                    if (({1'b0, tile_q} + 9'd1) < {1'b0, ntiles_q}) begin
                        state_d = LOAD_W;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wdim_q   <= WDIM_2X2;
            ntiles_q <= '0;
            alen_q   <= '0;
            tile_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdim_q   <= wdim_d;
            ntiles_q <= ntiles_d;
            alen_q   <= alen_d;
            tile_q   <= tile_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Combinational outputs are gated by rst so they read idle for the whole reset window.
    assign bus.busy     = !rst && (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.cfg_err  = err_q;
    assign bus.tile_idx = tile_q;
    assign bus.w_ps     = (!rst && ((state_q == STREAM) || (state_q == DRAIN))) ? '0 : '1;
    assign bus.out_en   = (!rst && (state_q == DRAIN)) ? (COL_ONE << (DW'(COL - 1) - dcnt)) : '0;
    assign bus.wgt_rd   = !rst && w_beat;
    assign bus.act_rd   = !rst && a_beat;

`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;
    logic        stalled;

    assign stalled = ((state_q == LOAD_W) && !bus.wgt_valid) ||
                     ((state_q == STREAM) && !bus.act_valid) ||
                     ((state_q == DRAIN)  && !bus.out_ready);

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && bus.start && !bus.abort)
            stall_d = '0;
        else if (stalled && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_systolic_sched.sv
// Bench for systolic_sched: directed table, hand-written corner sequences and randomized jobs vs a phase-level model.
module tb_systolic_sched;
    localparam int COL   = 32;
    localparam int ACT_W = 10;
    localparam int MAXC  = 2048;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_sched_if #(.COL(COL), .ACT_W(ACT_W)) sif ();
`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    systolic_sched #(.COL(COL), .ACT_W(ACT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
`ifdef SYSTOLIC_SCHED_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit wv [MAXC];
    bit av [MAXC];
    bit orr[MAXC];

    typedef struct {
        int wd;
        int nt;
        int al;
        int exp_done;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < MAXC; i++) begin
            wv[i] = 1'b1; av[i] = 1'b1; orr[i] = 1'b1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAXC; i++) begin
            wv[i]  = ($urandom_range(0, 3) != 0);
            av[i]  = ($urandom_range(0, 3) != 0);
            orr[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Phase-level model: walk the valid/ready patterns, consuming beats phase by phase.
    function automatic int model_done(input int wd, input int nt, input int al);
        int t = 1;
        for (int tile = 0; tile < nt; tile++) begin
            for (int k = 0; k < wd && t < MAXC; t++) if (wv[t]) k++;
            for (int k = 0; k < al && t < MAXC; t++) if (av[t]) k++;
            for (int k = 0; k < COL && t < MAXC; t++) if (orr[t]) k++;
            t++;
        end
        return t;
    endfunction

    function automatic bit is_legal(input int wd);
        return (wd == 4) || (wd == 9) || (wd == 16) || (wd == 25);
    endfunction

    task automatic idle_inputs();
        sif.start = 1'b0; sif.abort = 1'b0;
        sif.wgt_valid = 1'b1; sif.act_valid = 1'b1; sif.out_ready = 1'b1;
    endtask

    // One job: start in cycle 0, then cycles 1.. driven from the pattern arrays.
    task automatic run_job(input string name, input int wd, input int nt, input int al,
                           input int exp_done, input bit rnd_start);
        int  done_t = -1, err_t = -1, n_done = 0, n_err = 0;
        int  n_w = 0, n_a = 0, n_d = 0, exp_col = 0;
        int  col_bad = 0, mode_bad = 0, idle_bad = 0, freeze_bad = 0, seq_bad = 0;
        int  limit;
        bit  busy_seen = 0, legal;
        bit  prev_stall = 0;
        logic [COL-1:0] prev_en = '0;
        int  tiles_seen[$];
        longint stall_at_done = 0;

        legal = is_legal(wd);
        limit = (exp_done > 0 ? exp_done : 0) + 60;
        @(posedge clk); #1;
        sif.start = 1'b1; sif.abort = 1'b0;
        sif.cfg_weight_dim = 5'(wd); sif.cfg_num_tiles = 8'(nt); sif.cfg_act_len = ACT_W'(al);
        sif.wgt_valid = wv[0]; sif.act_valid = av[0]; sif.out_ready = orr[0];
        for (int t = 1; t <= limit; t++) begin
            @(posedge clk); #1;
            sif.start = rnd_start && (t < exp_done) && ($urandom_range(0, 15) == 0);
            sif.cfg_weight_dim = 5'($urandom);
            sif.cfg_num_tiles  = 8'($urandom);
            sif.cfg_act_len    = ACT_W'($urandom);
            sif.wgt_valid = wv[t % MAXC]; sif.act_valid = av[t % MAXC]; sif.out_ready = orr[t % MAXC];
            @(negedge clk);
            if (sif.busy) begin
                busy_seen = 1;
                if (tiles_seen.size() == 0 || tiles_seen[tiles_seen.size() - 1] != int'(sif.tile_idx))
                    tiles_seen.push_back(int'(sif.tile_idx));
            end else if (sif.w_ps != '1 || sif.out_en != '0) begin
                idle_bad++;
            end
            if (sif.wgt_rd) n_w++;
            if (sif.act_rd) n_a++;
            if ((sif.wgt_rd && (sif.w_ps != '1 || !sif.wgt_valid)) ||
                (sif.act_rd && (sif.w_ps != '0 || !sif.act_valid)))
                mode_bad++;
            if (prev_stall && sif.out_en != '0 && sif.out_en != prev_en) freeze_bad++;
            if (sif.out_en != '0 && sif.out_ready) begin
                if (sif.out_en != (COL'(1) << exp_col)) col_bad++;
                exp_col = (exp_col + 1) % COL;
                n_d++;
            end
            prev_stall = (sif.out_en != '0) && !sif.out_ready;
            prev_en    = sif.out_en;
            if (sif.cfg_err) begin n_err++; err_t = t; end
            if (sif.done) begin
                n_done++;
                if (done_t < 0) begin
                    done_t = t;
`ifdef SYSTOLIC_SCHED_PERF_EN
                    stall_at_done = longint'(stall_cnt);
`endif
                end
            end
            if (done_t >= 0 && t >= done_t + 3) break;
        end
        sif.start = 1'b0;
        for (int i = 0; i < tiles_seen.size(); i++) if (tiles_seen[i] != i) seq_bad++;

        check({name, " done_cycle"}, done_t, exp_done);
        check({name, " done_count"}, n_done, legal ? 1 : 0);
        check({name, " cfg_err_count"}, n_err, legal ? 0 : 1);
        if (!legal) check({name, " cfg_err_cycle"}, err_t, 1);
        check({name, " busy_seen"}, busy_seen, (legal && nt > 0) ? 1 : 0);
        check({name, " wgt_beats"}, n_w, legal ? nt * wd : 0);
        check({name, " act_beats"}, n_a, legal ? nt * al : 0);
        check({name, " drain_beats"}, n_d, legal ? nt * COL : 0);
        check({name, " drain_order_errs"}, col_bad, 0);
        check({name, " drain_freeze_errs"}, freeze_bad, 0);
        check({name, " wps_mode_errs"}, mode_bad, 0);
        check({name, " idle_output_errs"}, idle_bad, 0);
        check({name, " tile_count"}, tiles_seen.size(), legal ? nt : 0);
        check({name, " tile_order_errs"}, seq_bad, 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
        if (legal) check({name, " stall_cnt"}, stall_at_done, exp_done - 1 - nt * (wd + al + COL + 1));
`endif
    endtask

    initial begin
        int cnt_done, cnt_busy, exp;
        int legal_w[4] = '{4, 9, 16, 25};

        tbl[0] = '{wd: 9,  nt: 1, al: 4, exp_done: 47};
        tbl[1] = '{wd: 4,  nt: 2, al: 0, exp_done: 75};
        tbl[2] = '{wd: 25, nt: 1, al: 1, exp_done: 60};
        tbl[3] = '{wd: 16, nt: 0, al: 5, exp_done: 1};
        tbl[4] = '{wd: 7,  nt: 1, al: 4, exp_done: -1};
        tbl[5] = '{wd: 0,  nt: 2, al: 3, exp_done: -1};
        tbl[6] = '{wd: 16, nt: 3, al: 2, exp_done: 154};

        // Reset state while rst is held, with valids high on the buffer side.
        rst = 1'b1;
        idle_inputs();
        sif.cfg_weight_dim = 5'd9; sif.cfg_num_tiles = 8'd1; sif.cfg_act_len = ACT_W'(4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", sif.busy, 0);
        check("reset done", sif.done, 0);
        check("reset cfg_err", sif.cfg_err, 0);
        check("reset tile_idx", sif.tile_idx, 0);
        check("reset w_ps_ones", sif.w_ps == '1, 1);
        check("reset out_en", sif.out_en, 0);
        check("reset wgt_rd", sif.wgt_rd, 0);
        check("reset act_rd", sif.act_rd, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        fill_ones();
        for (int i = 0; i < 7; i++)
            run_job($sformatf("table%0d", i), tbl[i].wd, tbl[i].nt, tbl[i].al, tbl[i].exp_done, 1'b0);

        // Drain backpressure: out_ready low for five cycles in the middle of tile 0 drain.
        fill_ones();
        for (int t = 20; t <= 24; t++) orr[t] = 1'b0;
        run_job("drain_stall", 4, 3, 2, 123, 1'b0);

        // Weight stall of three cycles.
        fill_ones();
        for (int t = 2; t <= 4; t++) wv[t] = 1'b0;
        run_job("wgt_stall", 4, 1, 2, 43, 1'b0);

        // Abort during STREAM (cycles 5..12 for this job), then a fresh job.
        fill_ones();
        @(posedge clk); #1;
        idle_inputs();
        sif.start = 1'b1; sif.cfg_weight_dim = 5'd4; sif.cfg_num_tiles = 8'd2; sif.cfg_act_len = ACT_W'(8);
        for (int t = 1; t <= 7; t++) begin
            @(posedge clk); #1;
            sif.start = 1'b0;
            sif.abort = (t == 7);
            @(negedge clk);
        end
        check("abort in_stream", sif.act_rd, 1);
        @(posedge clk); #1;
        sif.abort = 1'b0;
        @(negedge clk);
        check("abort busy", sif.busy, 0);
        check("abort w_ps_ones", sif.w_ps == '1, 1);
        check("abort out_en", sif.out_en, 0);
        check("abort tile_idx", sif.tile_idx, 0);
        cnt_done = 0; cnt_busy = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (sif.done) cnt_done++;
            if (sif.busy) cnt_busy++;
        end
        check("abort no_done", cnt_done, 0);
        check("abort stays_idle", cnt_busy, 0);

        // Abort outranks a simultaneous start.
        @(posedge clk); #1;
        sif.start = 1'b1; sif.abort = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0; sif.abort = 1'b0;
        @(negedge clk);
        check("abort_vs_start busy", sif.busy, 0);
        check("abort_vs_start done", sif.done, 0);
        run_job("after_abort", 9, 1, 4, 47, 1'b0);

        // Reset mid-job discards it.
        @(posedge clk); #1;
        sif.start = 1'b1; sif.cfg_weight_dim = 5'd9; sif.cfg_num_tiles = 8'd2; sif.cfg_act_len = ACT_W'(4);
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1;
            sif.start = 1'b0;
            rst = (t >= 11);
        end
        @(negedge clk);
        check("midrst busy", sif.busy, 0);
        check("midrst w_ps_ones", sif.w_ps == '1, 1);
        check("midrst wgt_rd", sif.wgt_rd, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_done = 0; cnt_busy = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sif.done) cnt_done++;
            if (sif.busy) cnt_busy++;
        end
        check("midrst no_done", cnt_done, 0);
        check("midrst stays_idle", cnt_busy, 0);

        // Randomized jobs with random handshakes and ignored starts while busy.
        for (int j = 0; j < 10; j++) begin
            int wd, nt, al;
            fill_random();
            wd  = legal_w[$urandom_range(0, 3)];
            nt  = $urandom_range(0, 3);
            al  = $urandom_range(0, 10);
            exp = model_done(wd, nt, al);
            run_job($sformatf("rand%0d", j), wd, nt, al, exp, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
